// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared function codes, status bits, FSM states and instruction fields
package alu_pkg;

    localparam logic [3:0] NOP = 4'h0;
    localparam logic [3:0] ADD = 4'h1;
    localparam logic [3:0] SUB = 4'h2;
    localparam logic [3:0] MUL = 4'h3;
    localparam logic [3:0] AND = 4'h4;
    localparam logic [3:0] OR  = 4'h5;
    localparam logic [3:0] XOR = 4'h6;
    localparam logic [3:0] NOT = 4'h7;
    localparam logic [3:0] SHL = 4'h8;
    localparam logic [3:0] SHR = 4'h9;
    localparam logic [3:0] INC = 4'hA;
    localparam logic [3:0] DEC = 4'hB;
    localparam logic [3:0] CMP = 4'hC;

    localparam int EQU    = 0;
    localparam int NEQU   = 1;
    localparam int BTHAN  = 2;
    localparam int BEQUAL = 3;
    localparam int LTHAN  = 4;
    localparam int LEQUAL = 5;

    typedef enum logic [1:0] {IDLE, EXEC, FLAG} state_t;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 28;
    localparam int IMM_BIT = 27;
    localparam int RD_HI   = 26;
    localparam int RD_LO   = 24;
    localparam int RA_HI   = 23;
    localparam int RA_LO   = 21;
    localparam int RB_HI   = 20;
    localparam int RB_LO   = 18;

    // Only plain ALU functions write a result; CMP and illegal ops update flags only.
    function automatic logic op_writes(input logic [3:0] op);
        return op <= DEC;
    endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// rtl/alu_issue_stage_regfile.sv - 8x32 register file, two read ports plus debug, r0 hardwired to zero
module regfile8x32 #(
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [2:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_raddr_a,
    input  logic [2:0]  i_raddr_b,
    input  logic [2:0]  i_dbg_addr,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    output logic [31:0] o_dbg_data
);

    logic [31:0] r_mem [NREGS];

    // Clear wins over a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && i_waddr != 3'd0) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = (i_raddr_a  == 3'd0) ? 32'd0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == 3'd0) ? 32'd0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == 3'd0) ? 32'd0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - serialized issue/write-back stage feeding an external 32-bit ALU
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int IMM_W = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_imm_val,
    output logic        alu_imm,
    output logic [3:0]  alu_func,
    input  logic [31:0] alu_out,
    input  logic [7:0]  alu_status,
    output logic        done,
    output logic [7:0]  flags,
    output logic        illegal,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ireg;
    logic [7:0]  r_flags;
    logic [3:0]  w_op;
    logic [3:0]  w_func;
    logic        w_we;
    logic [31:0] w_rd_a;
    logic [31:0] w_rd_b;

    assign w_op = r_ireg[OP_HI:OP_LO];

    always_comb begin
        if (w_op == CMP)
            w_func = SUB;
        else if (op_writes(w_op))
            w_func = w_op;
        else
            w_func = NOP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ireg  <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && instr_valid)
                r_ireg <= instr;
            // alu_status was latched by the ALU at the EXEC edge.
            if (r_state == FLAG)
                r_flags <= alu_status;
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_imm_val = '0;
        alu_imm     = 1'b0;
        alu_func    = NOP;
        w_we        = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    w_next = EXEC;
            end
            EXEC: begin
                alu_a       = w_rd_a;
                alu_b       = w_rd_b;
                alu_imm     = r_ireg[IMM_BIT];
                alu_imm_val = {{(32-IMM_W){1'b0}}, r_ireg[IMM_W-1:0]};
                alu_func    = w_func;
                w_we        = op_writes(w_op);
                w_next      = FLAG;
            end
            FLAG: begin
                done    = 1'b1;
                illegal = (w_op > CMP);
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign flags = r_flags;

    regfile8x32 #(.NREGS(NREGS)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (r_ireg[RD_HI:RD_LO]),
        .i_wdata    (alu_out),
        .i_raddr_a  (r_ireg[RA_HI:RA_LO]),
        .i_raddr_b  (r_ireg[RB_HI:RB_LO]),
        .i_dbg_addr (dbg_addr),
        .o_rdata_a  (w_rd_a),
        .o_rdata_b  (w_rd_b),
        .o_dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a behavioural ALU alongside
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a, alu_b, alu_imm_val;
    logic        alu_imm;
    logic [3:0]  alu_func;
    logic [31:0] alu_out;
    logic [7:0]  alu_status = 8'h00;
    logic        done;
    logic [7:0]  flags;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_imm_val(alu_imm_val),
        .alu_imm(alu_imm), .alu_func(alu_func), .alu_out(alu_out), .alu_status(alu_status),
        .done(done), .flags(flags), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: combinational result, status latched every edge from the operands.
    logic [31:0] a_eff;
    assign a_eff = alu_imm ? alu_imm_val : alu_a;

    always_comb begin
        case (alu_func)
            ADD:     alu_out = a_eff + alu_b;
            SUB:     alu_out = a_eff - alu_b;
            INC:     alu_out = a_eff + 32'd1;
            DEC:     alu_out = a_eff - 32'd1;
            default: alu_out = a_eff;
        endcase
    end

    function automatic logic [7:0] cmp(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] s;
        s = 8'h00;
        s[EQU]    = (a == b);
        s[NEQU]   = (a != b);
        s[BTHAN]  = (a > b);
        s[BEQUAL] = (a >= b);
        s[LTHAN]  = (a < b);
        s[LEQUAL] = (a <= b);
        return s;
    endfunction

    always @(posedge clk) alu_status <= cmp(a_eff, alu_b);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] flags;
        logic       ill;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic       flag_pending = 1'b0;
    logic [7:0] flag_exp = 8'h00;

    // Monitor: illegal is checked with done, flags one cycle later.
    always @(negedge clk) begin
        if (flag_pending) begin
            chk("flags_after_done", {24'd0, flags}, {24'd0, flag_exp});
            flag_pending = 1'b0;
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                chk("illegal_at_done", {31'd0, illegal}, {31'd0, e.ill});
                flag_exp     = e.flags;
                flag_pending = 1'b1;
            end
        end
    end

    function automatic logic [31:0] mk(input logic [3:0] op, input logic im, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb, input logic [17:0] i18);
        return {op, im, rd, ra, rb, i18};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [7:0] ef, input logic eill,
                         input logic [3:0] efunc, input logic [2:0] da, input logic [31:0] dv);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
        sb.push_back('{ef, eill});
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ready_exec", {31'd0, instr_ready}, 32'd0);
        chk("func_exec", {28'd0, alu_func}, {28'd0, efunc});
        @(negedge clk);
        chk("ready_flag", {31'd0, instr_ready}, 32'd0);
        chk("done_flag", {31'd0, done}, 32'd1);
        dbg_addr = da;
        #1 chk("dbg_cycle2", dbg_data, dv);
        @(negedge clk);
        chk("ready_back", {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        dbg_addr    = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_flags", {24'd0, flags}, 32'd0);
        chk("rst_func", {28'd0, alu_func}, {28'd0, NOP});
        chk("rst_alu_a", alu_a, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(mk(NOP, 1'b1, 3'd1, 3'd0, 3'd0, 18'd5), 8'h0E, 1'b0, NOP, 3'd1, 32'd5);
        issue(mk(NOP, 1'b1, 3'd2, 3'd0, 3'd0, 18'd7), 8'h0E, 1'b0, NOP, 3'd2, 32'd7);
        issue(mk(ADD, 1'b0, 3'd3, 3'd1, 3'd2, 18'd0), 8'h32, 1'b0, ADD, 3'd3, 32'd12);
        issue(mk(NOP, 1'b1, 3'd1, 3'd0, 3'd0, 18'd9), 8'h0E, 1'b0, NOP, 3'd1, 32'd9);
        issue(mk(NOP, 1'b1, 3'd2, 3'd0, 3'd0, 18'd9), 8'h0E, 1'b0, NOP, 3'd2, 32'd9);
        issue(mk(CMP, 1'b0, 3'd3, 3'd1, 3'd2, 18'd0), 8'h29, 1'b0, SUB, 3'd3, 32'd12);
        issue(mk(4'hE, 1'b0, 3'd4, 3'd1, 3'd2, 18'd0), 8'h29, 1'b1, NOP, 3'd4, 32'd0);
        issue(mk(ADD, 1'b0, 3'd0, 3'd1, 3'd2, 18'd0), 8'h29, 1'b0, ADD, 3'd0, 32'd0);
        issue(mk(INC, 1'b0, 3'd1, 3'd1, 3'd0, 18'd0), 8'h0E, 1'b0, INC, 3'd1, 32'd10);

        // Reset lands on the EXEC edge of a write to R5: write and retire are both dropped.
        instr       = mk(NOP, 1'b1, 3'd5, 3'd0, 3'd0, 18'd3);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_flags", {24'd0, flags}, 32'd0);
        dbg_addr = 3'd5;
        #1 chk("abort_r5", dbg_data, 32'd0);
        dbg_addr = 3'd1;
        #1 chk("abort_r1_cleared", dbg_data, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end

        // instr_valid held high across the whole instruction: second accept only in cycle 3.
        sb.push_back('{8'h0E, 1'b0});
        sb.push_back('{8'h0E, 1'b0});
        instr       = mk(NOP, 1'b1, 3'd1, 3'd0, 3'd0, 18'd1);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_ready_c1", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("hold_ready_c2", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("hold_ready_c3", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("hold_ready_c4", {31'd0, instr_ready}, 32'd0);
        repeat (3) @(negedge clk);
        #1 chk("hold_r1", dbg_data, 32'd1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
